// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the multiplexed seven-segment
// display controller.
//   seg_t     : 8-bit segment vector {p,g,f,e,d,c,b,a}, active-low
//   SEG_BLANK : all segments off
//   HEX_SEG   : hex digit -> {g..a} pattern, active-low
//   MODE_HEX / MODE_RAW : values of the controller's mode input
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_RAW = 1'b1;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment pattern.
// Ports:
//   nib_i   : 4-bit hex value
//   point_i : decimal point enable, active-high
//   seg_o   : {p,g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       point_i,
    output seg_t       seg_o
);

    assign seg_o = {~point_i, HEX_SEG[nib_i]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit seven-segment display controller.
// Generates its own scan timing, decodes hex or passes raw segment bytes,
// applies per-digit decimal points and blink, and double-buffers display
// data so a new image only takes effect at a frame boundary.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   mode        : 0 = hex decode of hexs, 1 = raw bytes from raw_seg
//   hexs        : nibble per digit (digit 0 = bits [3:0])
//   raw_seg     : active-low segment byte per digit
//   point, les  : per-digit decimal point / blink enable
//   flash       : global blink enable
//   load, ready : capture handshake for the pending buffer
//   frame_start : one-cycle pulse after the scan index wraps to 0
//   seg, an     : registered active-low segment and anode outputs
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero
// digits in hex mode.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SCAN_DIV_W  = 16,
    parameter int BLINK_DIV_W = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [8*DIGITS-1:0]   raw_seg,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     les,
    input  logic                  flash,
    input  logic                  load,
    output logic                  ready,
    output logic                  frame_start,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [SCAN_DIV_W-1:0]  presc_q;
    logic [BLINK_DIV_W-1:0] blink_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   ready_q, fs_q;
    seg_t                   seg_q;
    logic [DIGITS-1:0]      an_q;

    // Pending buffer (written by load) and active buffer (being scanned).
    logic                   p_mode_q, a_mode_q;
    logic [4*DIGITS-1:0]    p_hex_q, a_hex_q;
    logic [8*DIGITS-1:0]    p_raw_q, a_raw_q;
    logic [DIGITS-1:0]      p_point_q, a_point_q;
    logic [DIGITS-1:0]      p_les_q, a_les_q;

    logic                   tick, wrap, load_ok;
    logic                   src_mode;
    logic [4*DIGITS-1:0]    src_hex;
    logic [8*DIGITS-1:0]    src_raw;
    logic [DIGITS-1:0]      src_point, src_les;
    logic [3:0]             nib;
    seg_t                   dec_seg, digit_seg;
    logic [DIGITS-1:0]      blank_mask;

    seg7_hex_decode u_dec (
        .nib_i   (nib),
        .point_i (src_point[idx_d]),
        .seg_o   (dec_seg)
    );

    always_comb begin
        tick    = (presc_q == '1);
        wrap    = tick && (idx_q == LAST_IDX);
        load_ok = load && ready_q;
        idx_d   = idx_q;
        if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

        // The wrap tick selects digit 0 of the frame being committed, so it
        // reads the pending buffer directly instead of the stale active one.
        src_mode  = wrap ? p_mode_q  : a_mode_q;
        src_hex   = wrap ? p_hex_q   : a_hex_q;
        src_raw   = wrap ? p_raw_q   : a_raw_q;
        src_point = wrap ? p_point_q : a_point_q;
        src_les   = wrap ? p_les_q   : a_les_q;

        nib = src_hex[idx_d*4 +: 4];
        if (src_mode == MODE_RAW)
            digit_seg = src_raw[idx_d*8 +: 8];
        else if (blank_mask[idx_d])
            digit_seg = SEG_BLANK;
        else
            digit_seg = dec_seg;
        if (flash && src_les[idx_d] && blink_q[BLINK_DIV_W-1])
            digit_seg = SEG_BLANK;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Blank every digit above the most significant non-zero nibble unless
    // its point is lit; digit 0 always shows. Mask is refreshed only when a
    // new frame commits (digit 0, shown at the wrap tick, never needs it).
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] h,
                                                  input logic [DIGITS-1:0]   p);
        logic              seen;
        logic [DIGITS-1:0] m;
        seen = 1'b0;
        m    = '0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            seen = seen || (h[i*4 +: 4] != 4'h0);
            m[i] = !seen && !p[i];
        end
        return m;
    endfunction

    logic [DIGITS-1:0] lz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lz_q <= '0;
        else if (wrap)
            lz_q <= (p_mode_q == MODE_HEX) ? lz_mask(p_hex_q, p_point_q) : '0;
    end

    assign blank_mask = lz_q;
`else
    assign blank_mask = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            blink_q   <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b1;
            fs_q      <= 1'b0;
            seg_q     <= SEG_BLANK;
            an_q      <= '1;
            p_mode_q  <= MODE_HEX;
            p_hex_q   <= '0;
            p_raw_q   <= '0;
            p_point_q <= '0;
            p_les_q   <= '0;
            a_mode_q  <= MODE_HEX;
            a_hex_q   <= '0;
            a_raw_q   <= '0;
            a_point_q <= '0;
            a_les_q   <= '0;
        end else begin
            presc_q <= presc_q + SCAN_DIV_W'(1);
            blink_q <= blink_q + BLINK_DIV_W'(1);
            fs_q    <= wrap;
            if (tick) begin
                idx_q <= idx_d;
                seg_q <= digit_seg;
                an_q  <= ~(DIGITS'(1) << idx_d);
            end
            if (load_ok) begin
                p_mode_q  <= mode;
                p_hex_q   <= hexs;
                p_raw_q   <= raw_seg;
                p_point_q <= point;
                p_les_q   <= les;
                ready_q   <= 1'b0;
            end else if (wrap) begin
                ready_q <= 1'b1;
            end
            if (wrap) begin
                a_mode_q  <= p_mode_q;
                a_hex_q   <= p_hex_q;
                a_raw_q   <= p_raw_q;
                a_point_q <= p_point_q;
                a_les_q   <= p_les_q;
            end
        end
    end

    assign ready       = ready_q;
    assign frame_start = fs_q;
    assign seg         = seg_q;
    assign an          = an_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for N digits, replacing the externally scanned single-digit path.
- Generates its own scan timing and decodes hex or raw segment data.
- Applies per-digit decimal points and per-digit blink enables.
- Double-buffers display data so updates never tear mid-frame.
- Sits between the CPU/IO bus display register and the board anode and segment pins.

Parameters:
DIGITS, 8, number of multiplexed digits (2..16)
SCAN_DIV_W, 16, prescaler width; one digit step every 2^SCAN_DIV_W clocks
BLINK_DIV_W, 25, blink counter width; blink phase = counter MSB

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
mode  in  1  0 = hex decode of hexs; 1 = raw segment patterns from raw_seg
hexs  in  4*DIGITS  nibble per digit; digit 0 = bits [3:0]
raw_seg  in  8*DIGITS  byte per digit {p,g,f,e,d,c,b,a}, active-low
point  in  DIGITS  decimal point enable per digit (hex mode only), active-high
les  in  DIGITS  blink enable per digit
flash  in  1  global blink enable
load  in  1  request capture of mode/hexs/raw_seg/point/les
ready  out  1  high when a load will be accepted
frame_start  out  1  one-cycle pulse when scan index wraps to 0
seg  out  8  {p,g,f,e,d,c,b,a}, active-low, registered
an  out  DIGITS  anode select, active-low one-hot, registered

Behaviour:
Reset values:
- seg=8'hFF; an=all ones; ready=1; frame_start=0.
- Scan index=0; prescaler=0; blink counter=0.
- Pending and active buffers all zero, mode=0.

Prescaler:
- Free-running SCAN_DIV_W-bit counter.
- tick asserted in the cycle the counter equals all ones; counter wraps to 0.

Scan index:
- Advances on tick: DIGITS-1 -> 0 wrap, else +1.
- frame_start pulses in the cycle after the tick that produces index 0.

Outputs:
- seg and an register on tick from the new index.
- 1-cycle latency from tick to pin change.
- Only one an bit low at any time after the first tick; all high before it.

Display data for digit i, from the active buffer:
- Hex mode: hex decode of nibble i; p segment = ~point[i].
- Raw mode: raw_seg byte i verbatim; point ignored.

Blink:
- Free-running BLINK_DIV_W counter; phase = MSB.
- If flash & les[i] & phase, digit i shows 8'hFF. Its anode is still driven.

Load handshake:
- load & ready in a cycle: all data inputs captured into the pending buffer; ready goes low the next cycle.
- load while ready=0: ignored, no error.
- At the tick that wraps the index to 0: pending copies to active, and ready returns high in the following cycle.
- The first digit of the new frame already uses the new data.
- load coincident with the wrap tick while ready=1: captured into pending; commits at the next wrap, not this one.

Mid-operation reset:
- Asynchronous reset blanks the display immediately.
- Any pending load is discarded.

Hex decode table (active-low, {g..a}):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- p bit prepended.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: in hex mode, digits above the most significant non-zero nibble are shown as 8'hFF, unless their point bit is set. Digit 0 is never blanked, so all-zero shows a single "0".
- Computed from the active buffer, once per commit, registered.
- Undefined: all digits always decoded.
- Raw mode is unaffected either way.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 8'hFF
  - 16-entry hex-to-segment constant table
  - typedef seg_t (8-bit)
  - MODE_HEX / MODE_RAW constants
- One sub-module seg7_hex_decode: combinational 4-bit nibble plus point -> seg_t using the package table.
- Scan, blink and buffering logic stay in the top.

Test Plan:
All with DIGITS=8, SCAN_DIV_W=2, BLINK_DIV_W=4.
1. Reset then idle, hexs=0 -> seg=FF and an=FF until the first tick; an then walks FE, FD, FB, ... 7F, FE every 4 clocks; frame_start pulses once per 32 clocks.
2. load with hexs=32'h89ABCDEF, point=8'h01, mode=0 -> digit 0 shows seg=8'h0E (F with dp on); digit 7 shows 8'h80. New values appear only from the next frame's digit 0; ready is low until then.
3. Second load while ready=0 with hexs=32'h0 -> ignored; display keeps 89ABCDEF.
4. mode=1, raw_seg byte 3 = 8'hA5, load -> when an=F7, seg=A5 exactly; point inputs have no effect.
5. flash=1, les=8'h04 -> digit 2 alternates between its decode and FF every 8 clocks; other digits are steady.
6. With SEG7_LEADING_ZERO_BLANK_EN, hexs=32'h00000120 -> digits 7..3 show FF, digits 2..0 show "120". With hexs=0 -> only digit 0 shows 8'hC0. Reset asserted mid-frame -> seg=FF and an=FF in the same cycle.
